// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch stage feeding the decoder.
//
// The stage holds the program counter and issues one request at a time to
// instruction memory. Memory answers in the same cycle it accepts
// (mem_ready), and each returned word enters a 2-entry queue together with
// its PC. The decoder consumes the queue head whenever it is not stalled.
// A jump redirect from downstream flushes the queue and restarts fetching
// at the jump target.
//
// Optional feature (macro FETCH_FLUSH_CNT_EN): adds the flush_count port,
// which counts redirects that threw away wrong-path work. The counter
// saturates at 0xFFFF.
//
// Ports:
//   clk, reset   clock and asynchronous active-high reset
//   mem_req      fetch request valid (high only in RUN)
//   mem_addr     fetch address (= fetch PC); changes only on accept/redirect
//   mem_ready    memory accepts request; mem_data valid in the same cycle
//   mem_data     returned instruction word
//   instr        queue head instruction
//   instr_pc     PC of queue head
//   instr_valid  queue non-empty
//   stall        decoder not consuming; head is held
//   jmp_valid    one-cycle redirect pulse
//   jmp_target   redirect address
//   state_dbg    current FSM state (BOOT=0, RUN=1, FULL=2)
//   flush_count  wrong-path flush counter (FETCH_FLUSH_CNT_EN only)
//
// Handshake: a request transfers in any cycle where mem_req && mem_ready.
// A queue entry is consumed in any cycle where instr_valid && !stall.
module fetch_stage #(
  parameter int ADDR_W   = 16,
  parameter int INSTR_W  = 32,
  parameter int RESET_PC = 0,
  parameter int PC_STEP  = 1
) (
  input  logic               clk,
  input  logic               reset,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ready,
  input  logic [INSTR_W-1:0] mem_data,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               stall,
  input  logic               jmp_valid,
  input  logic [ADDR_W-1:0]  jmp_target,
  output logic [1:0]         state_dbg
`ifdef FETCH_FLUSH_CNT_EN
  ,
  output logic [15:0]        flush_count
`endif
);

  localparam int ENT_W = INSTR_W + ADDR_W;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_FULL = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [1:0]        count_q, count_d;
  // e0 is always the head; e1 is the second entry when count == 2.
  logic [ENT_W-1:0]  e0_q, e0_d;
  logic [ENT_W-1:0]  e1_q, e1_d;

  logic accept;
  logic pop;

  assign mem_req     = (state_q == ST_RUN);
  assign mem_addr    = pc_q;
  assign accept      = mem_req && mem_ready;
  assign instr_valid = (count_q != 2'd0);
  assign pop         = instr_valid && !stall;
  assign instr       = e0_q[ENT_W-1:ADDR_W];
  assign instr_pc    = e0_q[ADDR_W-1:0];
  assign state_dbg   = state_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    e0_d    = e0_q;
    e1_d    = e1_q;
    if (state_q == ST_BOOT) begin
      // BOOT lasts exactly one cycle even if a redirect arrives.
      state_d = ST_RUN;
      if (jmp_valid) pc_d = jmp_target;
    end else if (jmp_valid) begin
      // Redirect wins over everything: the accepted word (if any) and the
      // queue contents are wrong-path and dropped.
      state_d = ST_RUN;
      pc_d    = jmp_target;
      count_d = 2'd0;
    end else begin
      if (pop) e0_d = e1_q;
      if (accept) begin
        // New word lands in the slot just past the surviving entries.
        if (count_q == 2'd0 || (count_q == 2'd1 && pop)) e0_d = {mem_data, pc_q};
        else                                             e1_d = {mem_data, pc_q};
        pc_d = pc_q + ADDR_W'(PC_STEP);
      end
      count_d = count_q + {1'b0, accept} - {1'b0, pop};
      state_d = (count_d == 2'd2) ? ST_FULL : ST_RUN;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_BOOT;
      pc_q    <= ADDR_W'(RESET_PC);
      count_q <= 2'd0;
      e0_q    <= '0;
      e1_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      e0_q    <= e0_d;
      e1_q    <= e1_d;
    end
  end

`ifdef FETCH_FLUSH_CNT_EN
  logic [15:0] flush_q, flush_d;

  always_comb begin
    flush_d = flush_q;
    // Only count redirects that actually discarded something.
    if (state_q != ST_BOOT && jmp_valid && (count_q != 2'd0 || accept) &&
        flush_q != 16'hFFFF)
      flush_d = flush_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) flush_q <= 16'd0;
    else       flush_q <= flush_d;
  end

  assign flush_count = flush_q;
`endif

endmodule
